mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage fed by the EXE/MEM register. Receives ALU result (address), store
//  data (val_rm) and control bits. Runs loads/stores against an internal word memory with a
//  fixed wait-state latency. Drives ready low to freeze the upstream pipeline during an access.
//  Its registered outputs form the MEM/WB register feeding write-back.
// PARAMETERS
//  DATA_W       32    data/address width
//  MEM_DEPTH    64    number of words in data memory
//  WAIT_CYCLES  3     wait states per access (>=1)
//  BASE_ADDR    1024  byte address mapped to word 0
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       asynchronous, active-low reset
//  wb_en_in       in   1       instruction writes a register
//  mem_read_in    in   1       load
//  mem_write_in   in   1       store
//  alu_res_in     in   DATA_W  ALU result / byte address
//  val_rm_in      in   DATA_W  store data
//  dest_in        in   4       destination register index
//  ready          out  1       0 = freeze upstream stages (combinational)
//  wb_en_out      out  1       MEM/WB: write-back enable
//  mem_read_out   out  1       MEM/WB: select mem data for write-back
//  alu_res_out    out  DATA_W  MEM/WB: ALU result
//  mem_data_out   out  DATA_W  MEM/WB: load data
//  dest_out       out  4       MEM/WB: destination register
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, counter=0, all MEM/WB outputs 0. Memory contents not reset.
//  - FSM states: IDLE, WAIT, DONE.
//  - IDLE, no mem op: ready=1; MEM/WB loads the inputs at the next edge (1-cycle latency).
//  - IDLE, mem_read_in|mem_write_in: ready=0; counter<=WAIT_CYCLES-1; go to WAIT.
//  - WAIT: ready=0.
//    - counter!=0: decrement.
//    - counter==0: at this edge the store writes memory / the load latches its read word; go to DONE.
//  - DONE: ready=1; MEM/WB captures the instruction plus the load data; go to IDLE.
//    - The next instruction is evaluated in IDLE, never in DONE, so a held op is not re-issued.
//  - Timing: a mem op is captured WAIT_CYCLES+2 cycles after it is first presented.
//    ready is low for WAIT_CYCLES+1 of those cycles.
//  - While ready=0: wb_en_out<=0 and mem_read_out<=0 (bubble to WB); other outputs hold.
//  - Address: idx=(alu_res_in-BASE_ADDR)>>2; bits [1:0] ignored.
//    - Out of range (addr<BASE_ADDR or idx>=MEM_DEPTH): store dropped, load returns 0.
//    - Stall timing is unchanged for out-of-range accesses.
//  - mem_read_in and mem_write_in both 1: treated as a store; mem_data_out=0.
//  - Inputs must stay stable while ready=0 (the upstream register is frozen).
//  - Reset asserted in IDLE/WAIT aborts the access; memory is not modified unless the WAIT->DONE
//    edge has already occurred.
//  - Store: mem_data_out=0, wb_en_out follows wb_en_in.
// STRUCTURE
//  - Width/length constants (REGISTER_LEN, ADDRESS_LEN, register-index width) come from defines.v.
//    Add MEM_BASE_ADDR and MEM_WAIT_CYCLES there as the parameter defaults.
//  - FSM state encoding is local localparams.
//  - One sub-module: data_memory (sync write, registered read, word-indexed, range-checked).
//  - Top level holds the FSM, wait counter, ready logic and MEM/WB register.
// TESTING (WAIT_CYCLES=3, BASE_ADDR=1024)
//  1. Non-mem op: alu_res=0x5, dest=3, wb_en=1.
//     -> ready stays 1; next cycle alu_res_out=0x5, dest_out=3, wb_en_out=1, mem_read_out=0.
//  2. Store 0xDEADBEEF to 1028.
//     -> ready low 4 cycles, high 1; wb_en_out=0 throughout.
//     Then load 1028, dest=7 -> after its 4-cycle stall: mem_data_out=0xDEADBEEF,
//     mem_read_out=1, wb_en_out=1, dest_out=7.
//  3. Back-to-back loads of 1028 then 1032 (holding 0x11).
//     -> two separate 4-low/1-high ready windows; outputs 0xDEADBEEF then 0x11; no re-issue in DONE.
//  4. Out of range: load 0x100 -> mem_data_out=0 after a normal stall.
//     Store 0x100 -> no word of the memory changes.
//  5. Reset in the 2nd WAIT cycle of store 0xCAFE to 1032 (holding 0x11).
//     -> outputs 0, state IDLE; a later load of 1032 returns 0x11.
//  6. mem_read=mem_write=1, store 0x22 to 1036.
//     -> memory[3]=0x22, mem_data_out=0, same stall as a store.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths and default parameters for the memory-access pipeline stage.
package mem_stage_pkg;

  localparam int unsigned REGISTER_LEN    = 32;
  localparam int unsigned ADDRESS_LEN     = 32;
  localparam int unsigned REG_IDX_W       = 4;
  localparam int unsigned MEM_DEPTH_DEF   = 64;
  localparam int unsigned MEM_BASE_ADDR   = 1024;
  localparam int unsigned MEM_WAIT_CYCLES = 3;

endpackage : mem_stage_pkg

// File: rtl/mem_stage_if.sv
// EXE/MEM inputs, stall handshake and MEM/WB outputs of the memory stage.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4
);

  logic              wb_en_in;
  logic              mem_read_in;
  logic              mem_write_in;
  logic [DATA_W-1:0] alu_res_in;
  logic [DATA_W-1:0] val_rm_in;
  logic [REG_W-1:0]  dest_in;
  logic              ready;
  logic              wb_en_out;
  logic              mem_read_out;
  logic [DATA_W-1:0] alu_res_out;
  logic [DATA_W-1:0] mem_data_out;
  logic [REG_W-1:0]  dest_out;

  // Upstream pipeline / testbench side
  modport master (
    output wb_en_in, mem_read_in, mem_write_in, alu_res_in, val_rm_in, dest_in,
    input  ready, wb_en_out, mem_read_out, alu_res_out, mem_data_out, dest_out
  );

  // Memory stage side
  modport slave (
    input  wb_en_in, mem_read_in, mem_write_in, alu_res_in, val_rm_in, dest_in,
    output ready, wb_en_out, mem_read_out, alu_res_out, mem_data_out, dest_out
  );

endinterface : mem_stage_if

// File: rtl/mem_stage_data_memory.sv
// Word-indexed data memory: synchronous write, registered read, range-checked byte address.
module mem_stage_data_memory #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned BASE_ADDR = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_en_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  // Byte offset from the window base; the wrap for addr < BASE_ADDR is excluded explicitly
  assign offset   = addr_i - DATA_W'(BASE_ADDR);
  assign in_range = (addr_i >= DATA_W'(BASE_ADDR)) && (offset < DATA_W'(MEM_DEPTH * 4));
  assign idx      = offset[IDX_W+1:2];

  // Storage array is not reset; out-of-range stores are dropped
  always_ff @(posedge clk) begin
    if (acc_en_i && we_i && in_range) begin
      mem_q[idx] <= wdata_i;
    end
  end

  // Read word latched on a load; stores and out-of-range loads return zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (acc_en_i) begin
      rdata_q <= (!we_i && in_range) ? mem_q[idx] : '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule : mem_stage_data_memory

// File: rtl/mem_stage.sv
// Memory-access stage: wait-state FSM, upstream freeze and MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W      = REGISTER_LEN,
  parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int unsigned WAIT_CYCLES = MEM_WAIT_CYCLES,
  parameter int unsigned BASE_ADDR   = MEM_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     wb_en_q, wb_en_d;
  logic                     mem_read_q, mem_read_d;
  logic [DATA_W-1:0]        alu_res_q, alu_res_d;
  logic [DATA_W-1:0]        mem_data_q, mem_data_d;
  logic [REG_IDX_W-1:0]     dest_q, dest_d;
  logic                     mem_op_c;
  logic                     mem_acc_c;
  logic [DATA_W-1:0]        rdata;

  assign mem_op_c = bus.mem_read_in | bus.mem_write_in;

  // Stall upstream while an access is being issued or is in flight
  assign bus.ready = ((state_q == S_IDLE) && !mem_op_c) || (state_q == S_DONE);

  mem_stage_data_memory #(
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) u_dmem (
    .clk      (clk),
    .rst      (rst),
    .acc_en_i (mem_acc_c),
    .we_i     (bus.mem_write_in),
    .addr_i   (bus.alu_res_in),
    .wdata_i  (bus.val_rm_in),
    .rdata_o  (rdata)
  );

  // Next state, wait counter and MEM/WB next values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_en_d    = wb_en_q;
    mem_read_d = mem_read_q;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    dest_d     = dest_q;
    mem_acc_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op_c) begin
          state_d    = S_WAIT;
          cnt_d      = CNT_W'(WAIT_CYCLES - 1);
          wb_en_d    = 1'b0;
          mem_read_d = 1'b0;
        end else begin
          wb_en_d    = bus.wb_en_in;
          mem_read_d = 1'b0;
          alu_res_d  = bus.alu_res_in;
          mem_data_d = '0;
          dest_d     = bus.dest_in;
        end
      end
      S_WAIT: begin
        wb_en_d    = 1'b0;
        mem_read_d = 1'b0;
        if (cnt_q == '0) begin
          state_d   = S_DONE;
          mem_acc_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // A combined read+write request behaves as a store
        state_d    = S_IDLE;
        wb_en_d    = bus.wb_en_in;
        mem_read_d = bus.mem_read_in & ~bus.mem_write_in;
        alu_res_d  = bus.alu_res_in;
        mem_data_d = rdata;
        dest_d     = bus.dest_in;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and MEM/WB register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wb_en_q    <= 1'b0;
      mem_read_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_en_q    <= wb_en_d;
      mem_read_q <= mem_read_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
      dest_q     <= dest_d;
    end
  end

  assign bus.wb_en_out    = wb_en_q;
  assign bus.mem_read_out = mem_read_q;
  assign bus.alu_res_out  = alu_res_q;
  assign bus.mem_data_out = mem_data_q;
  assign bus.dest_out     = dest_q;

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (WAIT_CYCLES=3, BASE_ADDR=1024).
module tb_mem_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_stage_if #(.DATA_W(32), .REG_W(4)) bus ();

  mem_stage #(
    .DATA_W      (32),
    .MEM_DEPTH   (64),
    .WAIT_CYCLES (3),
    .BASE_ADDR   (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
    bus.wb_en_in     = wb;
    bus.mem_read_in  = rd;
    bus.mem_write_in = wr;
    bus.alu_res_in   = alu;
    bus.val_rm_in    = val;
    bus.dest_in      = dest;
  endtask

  // Counts stalled cycles, then steps past the capture edge; bounded by a cycle budget
  task automatic run_access(output int lows, output bit bubble_ok, output bit timed_out);
    lows      = 0;
    bubble_ok = 1'b1;
    timed_out = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      lows++;
      if (lows > 1 && (bus.wb_en_out !== 1'b0 || bus.mem_read_out !== 1'b0)) bubble_ok = 1'b0;
      @(negedge clk); #1;
    end
    if (!timed_out) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 rst = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({bus.wb_en_out, bus.mem_read_out, bus.alu_res_out, bus.mem_data_out, bus.dest_out} !== 70'h0) begin
      errors++;
      $display("FAIL reset_outputs got wb=%b rd=%b alu=%h data=%h dest=%h required all 0",
               bus.wb_en_out, bus.mem_read_out, bus.alu_res_out, bus.mem_data_out, bus.dest_out);
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", bus.ready);
    end
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_nop();
    drive(1'b1, 1'b0, 1'b0, 32'h5, 32'h0, 4'd3);
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL nop_ready got %b required 1", bus.ready);
    end
    @(negedge clk); #1;
    checks++;
    if ({bus.wb_en_out, bus.mem_read_out, bus.alu_res_out, bus.dest_out} !== {1'b1, 1'b0, 32'h5, 4'd3}) begin
      errors++;
      $display("FAIL nop_capture got wb=%b rd=%b alu=%h dest=%0d required wb=1 rd=0 alu=5 dest=3",
               bus.wb_en_out, bus.mem_read_out, bus.alu_res_out, bus.dest_out);
    end
  endtask

  task automatic test_store_load();
    int lows; bit bok; bit to;
    drive(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd0);
    run_access(lows, bok, to);
    checks++;
    if (to || lows != 4 || !bok) begin
      errors++;
      $display("FAIL store_stall got lows=%0d bubble_ok=%0b timeout=%0b required lows=4 bubble_ok=1",
               lows, bok, to);
    end
    checks++;
    if ({bus.wb_en_out, bus.mem_data_out} !== {1'b0, 32'h0}) begin
      errors++;
      $display("FAIL store_capture got wb=%b data=%h required wb=0 data=0", bus.wb_en_out, bus.mem_data_out);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd7);
    run_access(lows, bok, to);
    checks++;
    if (to || lows != 4 || !bok) begin
      errors++;
      $display("FAIL load_stall got lows=%0d bubble_ok=%0b timeout=%0b required lows=4 bubble_ok=1",
               lows, bok, to);
    end
    checks++;
    if ({bus.mem_data_out, bus.mem_read_out, bus.wb_en_out, bus.dest_out} !== {32'hDEADBEEF, 1'b1, 1'b1, 4'd7}) begin
      errors++;
      $display("FAIL load_capture got data=%h rd=%b wb=%b dest=%0d required data=deadbeef rd=1 wb=1 dest=7",
               bus.mem_data_out, bus.mem_read_out, bus.wb_en_out, bus.dest_out);
    end
  endtask

  task automatic test_back_to_back();
    int lows; bit bok; bit to;
    drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'h11, 4'd0);
    run_access(lows, bok, to);
    drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd1);
    run_access(lows, bok, to);
    checks++;
    if (to || lows != 4 || bus.mem_data_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b_first got lows=%0d data=%h timeout=%0b required lows=4 data=deadbeef",
               lows, bus.mem_data_out, to);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd2);
    run_access(lows, bok, to);
    checks++;
    if (to || lows != 4 || !bok) begin
      errors++;
      $display("FAIL b2b_second_stall got lows=%0d bubble_ok=%0b timeout=%0b required lows=4 bubble_ok=1",
               lows, bok, to);
    end
    checks++;
    if ({bus.mem_data_out, bus.dest_out} !== {32'h11, 4'd2}) begin
      errors++;
      $display("FAIL b2b_second_data got data=%h dest=%0d required data=11 dest=2",
               bus.mem_data_out, bus.dest_out);
    end
  endtask

  task automatic test_out_of_range();
    int lows; bit bok; bit to;
    drive(1'b0, 1'b0, 1'b1, 32'd1024, 32'h5A5A, 4'd0);
    run_access(lows, bok, to);
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'd4);
    run_access(lows, bok, to);
    checks++;
    if (to || lows != 4 || bus.mem_data_out !== 32'h0) begin
      errors++;
      $display("FAIL oor_low_load got lows=%0d data=%h timeout=%0b required lows=4 data=0",
               lows, bus.mem_data_out, to);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h99, 4'd0);
    run_access(lows, bok, to);
    checks++;
    if (to || lows != 4) begin
      errors++;
      $display("FAIL oor_store_stall got lows=%0d timeout=%0b required lows=4", lows, to);
    end
    drive(1'b0, 1'b0, 1'b1, 32'd1280, 32'h77, 4'd0);
    run_access(lows, bok, to);
    drive(1'b1, 1'b1, 1'b0, 32'd1280, 32'h0, 4'd5);
    run_access(lows, bok, to);
    checks++;
    if (to || bus.mem_data_out !== 32'h0) begin
      errors++;
      $display("FAIL oor_high_load got data=%h timeout=%0b required data=0", bus.mem_data_out, to);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd6);
    run_access(lows, bok, to);
    checks++;
    if (to || bus.mem_data_out !== 32'h5A5A) begin
      errors++;
      $display("FAIL oor_word0_intact got data=%h timeout=%0b required data=5a5a", bus.mem_data_out, to);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd6);
    run_access(lows, bok, to);
    checks++;
    if (to || bus.mem_data_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL oor_word1_intact got data=%h timeout=%0b required data=deadbeef", bus.mem_data_out, to);
    end
  endtask

  task automatic test_reset_abort();
    int lows; bit bok; bit to;
    drive(1'b1, 1'b0, 1'b0, 32'hABC, 32'h0, 4'd9);
    @(negedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 32'd1032, 32'hCAFE, 4'd4);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.wb_en_out, bus.mem_read_out, bus.alu_res_out, bus.mem_data_out, bus.dest_out} !== 70'h0) begin
      errors++;
      $display("FAIL abort_outputs got wb=%b alu=%h dest=%h required all 0",
               bus.wb_en_out, bus.alu_res_out, bus.dest_out);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle_ready got %b required 1", bus.ready);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd8);
    run_access(lows, bok, to);
    checks++;
    if (to || lows != 4 || bus.mem_data_out !== 32'h11) begin
      errors++;
      $display("FAIL abort_mem_intact got lows=%0d data=%h timeout=%0b required lows=4 data=11",
               lows, bus.mem_data_out, to);
    end
  endtask

  task automatic test_read_write_both();
    int lows; bit bok; bit to;
    drive(1'b1, 1'b1, 1'b1, 32'd1036, 32'h22, 4'd5);
    run_access(lows, bok, to);
    checks++;
    if (to || lows != 4 || bus.mem_data_out !== 32'h0) begin
      errors++;
      $display("FAIL both_store got lows=%0d data=%h timeout=%0b required lows=4 data=0",
               lows, bus.mem_data_out, to);
    end
    drive(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd5);
    run_access(lows, bok, to);
    checks++;
    if (to || bus.mem_data_out !== 32'h22) begin
      errors++;
      $display("FAIL both_readback got data=%h timeout=%0b required data=22", bus.mem_data_out, to);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_nop();
    test_store_load();
    test_back_to_back();
    test_out_of_range();
    test_reset_abort();
    test_read_write_both();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_stage
